// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Almost-full must be reachable and non-trivial; almost-empty must be below full.
    function automatic bit thresholds_legal(input int addr_width, input int afull_th,
                                            input int aempty_th);
        return (afull_th >= 1) && (afull_th <= fifo_depth(addr_width)) &&
               (aempty_th >= 0) && (aempty_th <= fifo_depth(addr_width) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array: synchronous write, registered read with enable.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage is deliberately left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = mem_q[i_raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill level, programmable almost-full/empty thresholds,
// registered read port with valid strobe and sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_w_inc,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_r_inc,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_r_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int               DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LV  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AFULL_LV  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_LV = AEMPTY_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

    generate
        if (!thresholds_legal(ADDR_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_threshold
            $error("sync_fifo_param: AFULL_TH/AEMPTY_TH out of range for ADDR_WIDTH");
        end
    endgenerate

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                r_valid_q, r_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                full, empty, wr_ok, rd_ok;

    assign full  = (level_q == DEPTH_LV);
    assign empty = (level_q == '0);

    // A full FIFO still takes a write when a read frees a slot on the same edge;
    // an empty FIFO never forwards the incoming word to the read port.
    assign wr_ok = i_w_inc && (!full || (i_r_inc && !empty));
    assign rd_ok = i_r_inc && !empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        r_valid_d   = rd_ok;
        overflow_d  = (overflow_q && !i_clr_err) || (i_w_inc && !wr_ok);
        underflow_d = (underflow_q && !i_clr_err) || (i_r_inc && !rd_ok);
        if (wr_ok) begin
            wptr_d = wptr_q + ONE;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + ONE;
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            r_valid_q   <= r_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (wr_ok),
        .i_waddr (wptr_q[ADDR_WIDTH-1:0]),
        .i_wdata (i_w_data),
        .i_re    (rd_ok),
        .i_raddr (rptr_q[ADDR_WIDTH-1:0]),
        .o_rdata (o_r_data)
    );

    // The level counter must always agree with the wrapped pointer distance.
    level_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        level_q == (wptr_q - rptr_q));

    assign o_r_valid      = r_valid_q;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (level_q >= AFULL_LV);
    assign o_almost_empty = (level_q <= AEMPTY_LV);
    assign o_level        = level_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and randomized checks of sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_w_inc, i_r_inc, i_clr_err;
    logic [DW-1:0] i_w_data;
    logic [DW-1:0] o_r_data;
    logic          o_r_valid, o_full, o_empty, o_almost_full, o_almost_empty;
    logic [AW:0]   o_level;
    logic          o_overflow, o_underflow;

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AFULL_TH   (AF),
        .AEMPTY_TH  (AE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_w_inc        (i_w_inc),
        .i_w_data       (i_w_data),
        .i_r_inc        (i_r_inc),
        .i_clr_err      (i_clr_err),
        .o_r_data       (o_r_data),
        .o_r_valid      (o_r_valid),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_level        (o_level),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_data;
    logic          m_valid, m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        int lvl;
        lvl = mq.size();
        check({ctx, ":level"},   32'(o_level),        32'(lvl));
        check({ctx, ":full"},    32'(o_full),         32'(lvl == DEPTH));
        check({ctx, ":empty"},   32'(o_empty),        32'(lvl == 0));
        check({ctx, ":afull"},   32'(o_almost_full),  32'(lvl >= AF));
        check({ctx, ":aempty"},  32'(o_almost_empty), 32'(lvl <= AE));
        check({ctx, ":valid"},   32'(o_r_valid),      32'(m_valid));
        check({ctx, ":rdata"},   32'(o_r_data),       32'(m_data));
        check({ctx, ":ovf"},     32'(o_overflow),     32'(m_ovf));
        check({ctx, ":unf"},     32'(o_underflow),    32'(m_unf));
    endtask

    // Drive one cycle of requests, advance the model, then compare after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic clr, input string ctx);
        bit m_full, m_empty, wok, rok;
        i_w_inc   = w;
        i_w_data  = d;
        i_r_inc   = r;
        i_clr_err = clr;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        wok = w && (!m_full || (r && !m_empty));
        rok = r && !m_empty;
        m_valid = rok;
        if (rok) m_data = mq.pop_front();
        if (wok) mq.push_back(d);
        m_ovf = (m_ovf && !clr) || (w && !wok);
        m_unf = (m_unf && !clr) || (r && !rok);
        @(posedge clk);
        #1;
        i_w_inc   = 1'b0;
        i_r_inc   = 1'b0;
        i_clr_err = 1'b0;
        check_all(ctx);
        $display("step %-10s w=%0d d=%02h r=%0d clr=%0d -> level=%0d valid=%0d rdata=%02h ovf=%0d unf=%0d",
                 ctx, w, d, r, clr, o_level, o_r_valid, o_r_data, o_overflow, o_underflow);
    endtask

    initial begin
        rst       = 1'b1;
        i_w_inc   = 1'b0;
        i_r_inc   = 1'b0;
        i_clr_err = 1'b0;
        i_w_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "ovf_wr");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        check("drain_last", 32'(o_r_data), 32'h17);
        step(1'b0, 8'h00, 1'b1, 1'b0, "unf_rd");
        check("hold_17", 32'(o_r_data), 32'h17);
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "fill2");
        step(1'b1, 8'hAA, 1'b1, 1'b0, "full_wr_rd");
        check("full_both_oldest", 32'(o_r_data), 32'h20);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        check("aa_last", 32'(o_r_data), 32'hAA);

        step(1'b1, 8'h55, 1'b1, 1'b0, "empty_wr_rd");
        step(1'b0, 8'h00, 1'b1, 1'b0, "rd_55");
        check("got_55", 32'(o_r_data), 32'h55);
        step(1'b1, 8'h00, 1'b1, 1'b0, "fill_one");
        step(1'b1, 8'h01, 1'b0, 1'b0, "fill_one");
        for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "rd_two");
        step(1'b0, 8'h00, 1'b1, 1'b1, "clr_vs_set");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

        for (int i = 0; i < 48; i++) begin
            step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), "random");
        end

        i_w_inc  = 1'b1;
        i_w_data = 8'h77;
        i_r_inc  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        i_w_inc = 1'b0;
        i_r_inc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, "post_rst_wr");
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO for buffering UART TX/RX bytes when producer and consumer share one clock domain.
- Generalises data width and depth.
- Adds programmable almost-full/almost-empty thresholds, a fill-level output, a registered read port with valid strobe, and sticky overflow/underflow error flags with clear.
- Sits between the UART core and the host-side register interface.

Parameters:
DATA_WIDTH, 8, width of data words
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (8)
AFULL_TH, 6, o_almost_full asserts when level >= AFULL_TH (legal 1..DEPTH)
AEMPTY_TH, 1, o_almost_empty asserts when level <= AEMPTY_TH (legal 0..DEPTH-1)

Ports:
clk  in  1  operating clock, rising edge
rst  in  1  asynchronous active-high reset
i_w_inc  in  1  write request
i_w_data  in  DATA_WIDTH  write data
i_r_inc  in  1  read request
i_clr_err  in  1  synchronous clear of the sticky error flags
o_r_data  out  DATA_WIDTH  read data, registered
o_r_valid  out  1  o_r_data updated this cycle (one-cycle pulse per accepted read)
o_full  out  1  level == DEPTH
o_empty  out  1  level == 0
o_almost_full  out  1  level >= AFULL_TH
o_almost_empty  out  1  level <= AEMPTY_TH
o_level  out  ADDR_WIDTH+1  current fill level, 0..DEPTH
o_overflow  out  1  sticky: a write was rejected
o_underflow  out  1  sticky: a read was rejected

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - write and read pointers = 0, level = 0
  - o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0 (unless AFULL_TH = 0, which is illegal)
  - o_r_data = 0, o_r_valid = 0, o_overflow = 0, o_underflow = 0
  - Memory array is not reset.
- Pointers:
  - ADDR_WIDTH+1-bit binary; low ADDR_WIDTH bits address the RAM.
  - MSB is the wrap bit; wrap from DEPTH-1 to 0 toggles it.
  - level = wptr - rptr (modulo 2**(ADDR_WIDTH+1)). Held in a registered counter, checked against the pointer difference by assertion.
- Accept rules, evaluated on the pre-edge state:
  - wr_ok = i_w_inc && (!full || (i_r_inc && !empty))
  - rd_ok = i_r_inc && !empty
- Full + write + read in the same cycle: both accepted, level unchanged.
- Empty + write + read in the same cycle: write accepted, read rejected. Underflow sets, level becomes 1. No write-to-read bypass.
- Level update on each edge: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- Read path:
  - On rd_ok, o_r_data <= mem[rptr] and o_r_valid = 1 on the following cycle, i.e. 1-cycle read latency.
  - o_r_data holds its last value otherwise.
  - o_r_valid is 0 in any cycle not following an rd_ok.
- Write path: on wr_ok, mem[wptr] <= i_w_data at the edge.
- Status flags are combinational from the registered level, so they change in the cycle after the accepting edge with no extra latency. o_level equals the registered level.
- Errors:
  - i_w_inc && !wr_ok sets o_overflow.
  - i_r_inc && !rd_ok sets o_underflow.
  - Both flags are sticky until i_clr_err.
  - If i_clr_err and a new error occur in the same cycle, set wins.
  - Rejected requests never move pointers or modify memory.
- Reset asserted mid-operation: all state returns to reset values immediately. Stored data is logically discarded.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants
  - a function computing DEPTH from ADDR_WIDTH
  - elaboration-time threshold legality checks
- One sub-module, sync_fifo_ram: simple dual-port register array with a synchronous write port and a registered read port (read enable, read address, data out), parametrised by DATA_WIDTH/ADDR_WIDTH.
- Pointer, level, flag and error logic live in sync_fifo_param.

Test Plan:
- Reset then idle → o_empty = 1, o_almost_empty = 1, o_level = 0, o_r_valid = 0, no error flags.
- Write 8 bytes 0x10..0x17 back-to-back → o_level steps 1..8:
  - o_almost_full rises after the 6th write
  - o_full = 1 after the 8th
  - a 9th write sets o_overflow, and o_level stays 8
- Read 8 from full → o_r_valid pulses each cycle after a read, data 0x10..0x17 in order, o_empty = 1 after the last. A further read sets o_underflow; o_r_data holds 0x17.
- Fill to 8, assert write (0xAA) and read together for one cycle → o_r_data = oldest word, o_level stays 8, no overflow. 0xAA is later read last.
- Empty FIFO, write 0x55 and read together → o_underflow = 1, o_level = 1, o_r_valid = 0. Next-cycle read returns 0x55. Pulse i_clr_err clears both error flags.
- Stream 20 words with random interleaved reads (pointer wrap twice), then assert rst mid-stream → scoreboard matches before reset. After reset, all outputs return to reset values within the same cycle (asynchronous).
